// File: rtl/cmp_pkg.sv
// Shared types and constants for the RGB comparator self-test sequencer.
package cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    typedef struct packed {
        logic red;
        logic green;
        logic blue;
    } rgb_t;

    localparam rgb_t RGB_GT = 3'b100;
    localparam rgb_t RGB_EQ = 3'b010;
    localparam rgb_t RGB_LT = 3'b001;

endpackage

// File: rtl/cmp_expect.sv
// Golden comparator model: one-hot {red,green,blue} for a>b, a==b, a<b.
module cmp_expect
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output rgb_t             rgb_c
);

    always_comb begin
        rgb_c = RGB_EQ;
        if (a > b) begin
            rgb_c = RGB_GT;
        end else if (a < b) begin
            rgb_c = RGB_LT;
        end
    end

endmodule

// File: rtl/cmp_sweep_checker.sv
// Sweeps every a/b pair into the comparator, checks each response against
// the golden model and reports error count plus the first failing vector.
module cmp_sweep_checker
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 red_in,
    input  logic                 green_in,
    input  logic                 blue_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int unsigned IDX_W = 2 * WIDTH;
    localparam int unsigned ERR_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               busy_n, done_n, pass_n, fail_valid_n;
    logic [ERR_W-1:0]   err_n;
    logic [WIDTH-1:0]   fail_a_n, fail_b_n;
    rgb_t               rsp;
    rgb_t               expect_c;
    logic               mismatch;

    assign a_out    = idx[IDX_W-1:WIDTH];
    assign b_out    = idx[WIDTH-1:0];
    assign rsp      = {red_in, green_in, blue_in};
    assign mismatch = (rsp != expect_c);

    cmp_expect #(.WIDTH(WIDTH)) u_expect (
        .a     (a_out),
        .b     (b_out),
        .rgb_c (expect_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
            fail_valid <= fail_valid_n;
            fail_a     <= fail_a_n;
            fail_b     <= fail_b_n;
        end
    end

    // Next-state and registered-output decode; status flags follow the next state.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        err_n        = err_count;
        fail_valid_n = fail_valid;
        fail_a_n     = fail_a;
        fail_b_n     = fail_b;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n      = S_SETTLE;
                    idx_n        = '0;
                    cnt_n        = '0;
                    err_n        = '0;
                    fail_valid_n = 1'b0;
                    fail_a_n     = '0;
                    fail_b_n     = '0;
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    cnt_n   = '0;
                    state_n = S_CHECK;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_n = err_count + ERR_W'(1);
                    if (!fail_valid) begin
                        fail_valid_n = 1'b1;
                        fail_a_n     = a_out;
                        fail_b_n     = b_out;
                    end
                end
                if (idx == {IDX_W{1'b1}}) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = S_SETTLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_SETTLE) || (state_n == S_CHECK);
        done_n = (state_n == S_DONE);
        pass_n = done_n && (err_n == '0);
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Self-checking bench: a fault-injectable comparator drives two checkers
// (SETTLE=2 and SETTLE=1); results are compared with an arithmetic model.
module tb_cmp_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_n0, start0, red0, green0, blue0, busy0, done0, pass0, fv0;
    logic [1:0] a0, b0, fa0, fb0;
    logic [4:0] ec0;
    logic rst_n1, start1, red1, green1, blue1, busy1, done1, pass1, fv1;
    logic [1:0] a1, b1, fa1, fb1;
    logic [4:0] ec1;

    int         mode0 = 0;
    int         mode1 = 0;
    logic [2:0] mask0 [16];
    logic [2:0] mask1 [16];

    // 0: correct, 1: green stuck at 0, 2: red/blue swapped, 3: per-vector xor mask
    function automatic logic [2:0] resp_f(int a, int b, int mode, logic [2:0] m);
        logic [2:0] c;
        c = {a > b, a == b, a < b};
        case (mode)
            1:       return c & 3'b101;
            2:       return {c[0], c[1], c[2]};
            3:       return c ^ m;
            default: return c;
        endcase
    endfunction

    assign {red0, green0, blue0} = resp_f(int'(a0), int'(b0), mode0, mask0[{a0, b0}]);
    assign {red1, green1, blue1} = resp_f(int'(a1), int'(b1), mode1, mask1[{a1, b1}]);

    cmp_sweep_checker #(.WIDTH(2), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n0), .start(start0), .a_out(a0), .b_out(b0),
        .red_in(red0), .green_in(green0), .blue_in(blue0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
        .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0)
    );

    cmp_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .a_out(a1), .b_out(b1),
        .red_in(red1), .green_in(green1), .blue_in(blue1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    int exp_err, exp_fa, exp_fb;
    bit exp_fv;

    // Expected summary from the comparison rules over all 16 vectors in sweep order.
    task automatic model(input int mode, input logic [2:0] m [16]);
        logic [2:0] golden, r;
        exp_err = 0; exp_fv = 0; exp_fa = 0; exp_fb = 0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                golden = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
                r = resp_f(a, b, mode, m[a*4+b]);
                if (r !== golden) begin
                    exp_err++;
                    if (!exp_fv) begin
                        exp_fv = 1; exp_fa = a; exp_fb = b;
                    end
                end
            end
        end
    endtask

    task automatic randomize_mask0();
        for (int i = 0; i < 16; i++)
            mask0[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    endtask

    task automatic randomize_mask1();
        for (int i = 0; i < 16; i++)
            mask1[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    endtask

    task automatic test_reset();
        rst_n0 = 1'b0; rst_n1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({a0, b0, busy0, done0, pass0, ec0, fv0, fa0, fb0} !== 17'd0) begin
            errors++;
            $display("FAIL reset0: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b fa=%0d fb=%0d, want all 0",
                     a0, b0, busy0, done0, pass0, ec0, fv0, fa0, fb0);
        end
        checks++;
        if ({a1, b1, busy1, done1, pass1, ec1, fv1, fa1, fb1} !== 17'd0) begin
            errors++;
            $display("FAIL reset1: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b fa=%0d fb=%0d, want all 0",
                     a1, b1, busy1, done1, pass1, ec1, fv1, fa1, fb1);
        end
    endtask

    task automatic pulse0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait_done0(output int n);
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_sweep(input int mode, input string name);
        int n;
        mode0 = mode;
        if (mode == 3) randomize_mask0();
        model(mode, mask0);
        pulse0();
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: busy=%b done=%b, want busy=1 done=0", name, busy0, done0);
        end
        wait_done0(n);
        checks++;
        if (n != 48) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles, want 48", name, n);
        end
        checks++;
        if (busy0 !== 1'b0 || pass0 !== (exp_err == 0)) begin
            errors++;
            $display("FAIL %s_status: busy=%b pass=%b, want busy=0 pass=%b", name, busy0, pass0, exp_err == 0);
        end
        checks++;
        if (ec0 !== 5'(exp_err) || fv0 !== exp_fv) begin
            errors++;
            $display("FAIL %s_errcount: err=%0d fv=%b, want err=%0d fv=%b", name, ec0, fv0, exp_err, exp_fv);
        end
        checks++;
        if (fa0 !== 2'(exp_fa) || fb0 !== 2'(exp_fb)) begin
            errors++;
            $display("FAIL %s_first: fail_a=%0d fail_b=%0d, want %0d/%0d", name, fa0, fb0, exp_fa, exp_fb);
        end
        checks++;
        if (a0 !== 2'd3 || b0 !== 2'd3) begin
            errors++;
            $display("FAIL %s_lastvec: a=%0d b=%0d, want 3/3", name, a0, b0);
        end
    endtask

    task automatic test_start_mid_sweep();
        int n;
        mode0 = 0;
        pulse0();
        n = 0;
        repeat (19) begin @(negedge clk); n++; end
        start0 = 1'b1;
        @(negedge clk); n++;
        start0 = 1'b0;
        checks++;
        if ({a0, b0} !== 4'(n / 3) || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_idx: vec=%0d busy=%b, want vec=%0d busy=1", {a0, b0}, busy0, n / 3);
        end
        while (!done0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n != 48 || pass0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_done: done at %0d pass=%b, want 48 pass=1", n, pass0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        mode0 = 1;
        pulse0();
        repeat (29) @(negedge clk);
        rst_n0 = 1'b0;
        @(negedge clk);
        rst_n0 = 1'b1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, ec0, fv0, fa0, fb0} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: got a=%0d b=%0d busy=%b done=%b err=%0d fv=%b, want all 0",
                     a0, b0, busy0, done0, ec0, fv0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || {a0, b0} !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b done=%b vec=%0d, want 0/0/0", busy0, done0, {a0, b0});
        end
        test_sweep(0, "after_reset");
    endtask

    task automatic test_reset_beats_start();
        @(negedge clk);
        rst_n0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        rst_n0 = 1'b1; start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || ec0 !== 5'd0) begin
            errors++;
            $display("FAIL reset_vs_start: busy=%b done=%b err=%0d, want 0/0/0", busy0, done0, ec0);
        end
    endtask

    task automatic test_settle1_restart();
        int n;
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            mode1 = 3;
            randomize_mask1();
            mask1[5] = 3'b010;
            model(3, mask1);
            @(negedge clk); start1 = 1'b1;
            @(negedge clk); start1 = 1'b0;
            checks++;
            if (done1 !== 1'b0 || ec1 !== 5'd0 || fv1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL s1_accept%0d: done=%b err=%0d fv=%b busy=%b, want 0/0/0/1",
                         pass_i, done1, ec1, fv1, busy1);
            end
            n = 0;
            while (!done1 && n < 200) begin @(negedge clk); n++; end
            checks++;
            if (n != 32) begin
                errors++;
                $display("FAIL s1_latency%0d: done after %0d cycles, want 32", pass_i, n);
            end
            checks++;
            if (ec1 !== 5'(exp_err) || fv1 !== exp_fv || fa1 !== 2'(exp_fa) || fb1 !== 2'(exp_fb) || pass1 !== 1'b0) begin
                errors++;
                $display("FAIL s1_result%0d: err=%0d fv=%b fa=%0d fb=%0d pass=%b, want err=%0d fv=%b fa=%0d fb=%0d pass=0",
                         pass_i, ec1, fv1, fa1, fb1, pass1, exp_err, exp_fv, exp_fa, exp_fb);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mask0[i] = 3'b000;
            mask1[i] = 3'b000;
        end
        test_reset();
        test_sweep(0, "correct");
        test_sweep(1, "green_stuck");
        test_sweep(2, "rb_swap");
        for (int k = 0; k < 4; k++) test_sweep(3, "random");
        test_start_mid_sweep();
        test_reset_mid_sweep();
        test_reset_beats_start();
        test_settle1_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
